// File: rtl/i2s_pkg.sv
// Shared constants and FSM encoding for the I2S receiver.
package i2s_pkg;
    localparam int CNT_W            = 6;
    localparam int MIN_CLK_PER_BCLK = 6;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_SEEK  = 2'd0;
    localparam logic [1:0] ST_LEFT  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;
endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-flop synchronizer with edge detect; edges are taken against the level
// held at the last 'sample' strobe, so a strobe of 1 gives plain clk-rate edges.
module i2s_sync_edge
    import i2s_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    input  logic sample,
    output logic lvl,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            if (sample) prev_q <= lvl;
        end
    end

    assign lvl  = sync_q[SYNC_STAGES-1];
    assign rise = sample & lvl & ~prev_q;
    assign fall = sample & ~lvl & prev_q;
endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples BCLK/LRCK/SDATA on clk, frames slots by LRCK edges
// and emits one stereo word per complete, correctly sized left+right frame.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int SLOT_BITS   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    i2s_bclk,
    input  logic                    i2s_lrck,
    input  logic                    i2s_sdata,
    output logic [2*DATA_WIDTH-1:0] audio_out,
    output logic                    audio_valid,
    output logic                    frame_err,
    output logic                    locked
);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic                   bclk_lvl, bclk_rise, bclk_fall;
    logic                   lrck_lvl, lr_rise, lr_fall;
    logic [SYNC_STAGES-1:0] sdata_q;
    logic                   unused_edges;

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bclk (
        .clk(clk), .reset_n(reset_n), .din(i2s_bclk), .sample(1'b1),
        .lvl(bclk_lvl), .rise(bclk_rise), .fall(bclk_fall)
    );

    // LRCK edges are judged only at BCLK rises, so they mark slot boundaries.
    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lrck (
        .clk(clk), .reset_n(reset_n), .din(i2s_lrck), .sample(bclk_rise),
        .lvl(lrck_lvl), .rise(lr_rise), .fall(lr_fall)
    );

    assign unused_edges = bclk_lvl ^ bclk_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sdata_q <= '0;
        end else begin
            sdata_q[0] <= i2s_sdata;
            for (int i = 1; i < SYNC_STAGES; i++) sdata_q[i] <= sdata_q[i-1];
        end
    end

    state_t                  state;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [DATA_WIDTH-1:0]   left_reg, right_reg;
    logic                    slot_edge, shift_en, overflow;

    assign slot_edge = lr_rise | lr_fall;

    always_comb begin
        cnt_next = cnt;
        if (slot_edge)            cnt_next = '0;
        else if (cnt != CNT_MAX)  cnt_next = cnt + 1'b1;
    end

    // Bit 0 of each slot is the I2S delay bit; only 1..DATA_WIDTH carry data.
    assign shift_en = bclk_rise & ~slot_edge & (cnt_next <= DATA_LAST);
    assign overflow = ~slot_edge & (cnt == CNT_MAX - 1'b1);
    assign locked   = (state != ST_SEEK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_SEEK;
            cnt         <= '0;
            left_reg    <= '0;
            right_reg   <= '0;
            audio_out   <= '0;
            audio_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            audio_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (bclk_rise) begin
                cnt <= cnt_next;
                if (shift_en) begin
                    if (lrck_lvl) right_reg <= {right_reg[DATA_WIDTH-2:0], sdata_q[SYNC_STAGES-1]};
                    else          left_reg  <= {left_reg[DATA_WIDTH-2:0], sdata_q[SYNC_STAGES-1]};
                end
            end
            if (!enable) begin
                state <= ST_SEEK;
            end else if (bclk_rise) begin
                case (state)
                    ST_SEEK: if (lr_fall) state <= ST_LEFT;
                    ST_LEFT: begin
                        if (lr_rise) begin
                            if (cnt == SLOT_LAST) state <= ST_RIGHT;
                            else begin
                                frame_err <= 1'b1;
                                state     <= ST_SEEK;
                            end
                        end else if (overflow) begin
                            frame_err <= 1'b1;
                            state     <= ST_SEEK;
                        end
                    end
                    ST_RIGHT: begin
                        // A falling edge always opens a new left slot, even after a bad right slot.
                        if (lr_fall) begin
                            state <= ST_LEFT;
                            if (cnt == SLOT_LAST) begin
                                audio_out   <= {left_reg, right_reg};
                                audio_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else if (overflow) begin
                            frame_err <= 1'b1;
                            state     <= ST_SEEK;
                        end
                    end
                    default: state <= ST_SEEK;
                endcase
            end
        end
    end
endmodule
